// File: rtl/rcp_sequencer.sv
// rcp_sequencer: feeds an X/Y operand pair through one shared start/done
// reciprocal device, one operand at a time, and returns both results together
// on a valid/ready port. Zero operands and a device that never answers both
// produce the saturated value nSat, so the tracer is never stalled.
module rcp_sequencer #(
    parameter int M       = 12,
    parameter int N       = 12,
    parameter int TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [M+N-1:0]   i_x,
    input  logic [M+N-1:0]   i_y,
    input  logic             i_abs,
    output logic             o_rcp_start,
    output logic [M+N-1:0]   o_rcp_data,
    output logic             o_rcp_abs,
    input  logic [M+N-1:0]   i_rcp_data,
    input  logic             i_rcp_sat,
    input  logic             i_rcp_done,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [M+N-1:0]   o_rx,
    output logic [M+N-1:0]   o_ry,
    output logic             o_sat_x,
    output logic             o_sat_y,
    output logic             o_timeout
);

    localparam int W  = M + N;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] NSAT = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE, ISSUE_X, WAIT_X, ISSUE_Y, WAIT_Y, OUT
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   x_q, y_q;
    logic           abs_q;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   data_q;     // last operand presented to the device
    logic           rabs_q;     // last abs flag presented to the device
    logic [W-1:0]   cur_op;
    logic           cnt_last;

    // The operand being issued depends only on which ISSUE state we are in.
    assign cur_op   = (state == ISSUE_Y) ? y_q : x_q;
    // The wait window expires on the cycle the counter would reach zero.
    assign cnt_last = (cnt == CW'(1));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic; a done in WAIT takes priority over expiry
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_valid) state_nx = ISSUE_X;
            ISSUE_X: state_nx = (x_q != '0) ? WAIT_X : ISSUE_Y;
            WAIT_X:  if (i_rcp_done || cnt_last) state_nx = ISSUE_Y;
            ISSUE_Y: state_nx = (y_q != '0) ? WAIT_Y : OUT;
            WAIT_Y:  if (i_rcp_done || cnt_last) state_nx = OUT;
            OUT:     if (i_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state; device operand/abs hold between issues
    always_comb begin
        o_ready     = (state == IDLE);
        o_valid     = (state == OUT);
        o_rcp_start = ((state == ISSUE_X) || (state == ISSUE_Y)) && (cur_op != '0);
        o_rcp_data  = o_rcp_start ? cur_op : data_q;
        o_rcp_abs   = o_rcp_start ? abs_q  : rabs_q;
    end

    // Datapath: operand latch, wait counter, result capture / substitution
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            x_q       <= '0;
            y_q       <= '0;
            abs_q     <= 1'b0;
            cnt       <= '0;
            data_q    <= '0;
            rabs_q    <= 1'b0;
            o_rx      <= '0;
            o_ry      <= '0;
            o_sat_x   <= 1'b0;
            o_sat_y   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            if (o_rcp_start) begin
                data_q <= cur_op;
                rabs_q <= abs_q;
            end
            case (state)
                IDLE: if (i_valid) begin
                    x_q       <= i_x;
                    y_q       <= i_y;
                    abs_q     <= i_abs;
                    o_timeout <= 1'b0;
                end
                ISSUE_X: begin
                    if (x_q != '0) cnt <= CW'(TIMEOUT);
                    else begin
                        o_rx    <= NSAT;
                        o_sat_x <= 1'b1;
                    end
                end
                WAIT_X: begin
                    if (i_rcp_done) begin
                        o_rx    <= i_rcp_data;
                        o_sat_x <= i_rcp_sat;
                    end else if (cnt_last) begin
                        o_rx      <= NSAT;
                        o_sat_x   <= 1'b1;
                        o_timeout <= 1'b1;
                    end else cnt <= cnt - CW'(1);
                end
                ISSUE_Y: begin
                    if (y_q != '0) cnt <= CW'(TIMEOUT);
                    else begin
                        o_ry    <= NSAT;
                        o_sat_y <= 1'b1;
                    end
                end
                WAIT_Y: begin
                    if (i_rcp_done) begin
                        o_ry    <= i_rcp_data;
                        o_sat_y <= i_rcp_sat;
                    end else if (cnt_last) begin
                        o_ry      <= NSAT;
                        o_sat_y   <= 1'b1;
                        o_timeout <= 1'b1;
                    end else cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rcp_sequencer.sv
// Bench for rcp_sequencer: behavioural 4-cycle reciprocal device, a
// transaction-level timeline/result model, and a per-cycle compare process.
module tb_rcp_sequencer;

    localparam int M = 12, N = 12, TIMEOUT = 15;
    localparam int W = M + N;
    localparam logic [W-1:0] NSAT = {1'b0, {(W-1){1'b1}}};

    logic i_clk = 1'b0, i_reset = 1'b1;
    logic i_valid = 1'b0, i_abs = 1'b0, i_ready = 1'b0;
    logic [W-1:0] i_x = '0, i_y = '0;
    logic o_ready, o_rcp_start, o_rcp_abs, o_valid, o_sat_x, o_sat_y, o_timeout;
    logic [W-1:0] o_rcp_data, o_rx, o_ry;
    logic [W-1:0] dev_data = '0;
    logic dev_sat = 1'b0, dev_done = 1'b0;

    rcp_sequencer #(.M(M), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_x(i_x), .i_y(i_y), .i_abs(i_abs),
        .o_rcp_start(o_rcp_start), .o_rcp_data(o_rcp_data), .o_rcp_abs(o_rcp_abs),
        .i_rcp_data(dev_data), .i_rcp_sat(dev_sat), .i_rcp_done(dev_done),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_rx(o_rx), .o_ry(o_ry), .o_sat_x(o_sat_x), .o_sat_y(o_sat_y),
        .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int vectors = 0, errors = 0;
    bit chk_en = 1'b0;

    // model of the transaction in flight
    bit active = 1'b0;
    int a_c, sx_c = -1, sy_c = -1, v_c, e_c;
    logic [W-1:0] e_rx, e_ry, e_xop, e_yop;
    bit e_sx, e_sy, e_to, e_abs, hang_x, hang_y, inj = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // exact reciprocal in SQM.N: 2^(2N)/|x|, clamped to nSat, sign restored unless abs
    function automatic logic [W:0] dev_fn(input logic [W-1:0] x, input logic ab);
        longint unsigned mag, q;
        logic [W-1:0] res;
        logic sat;
        mag = x[W-1] ? ((64'd1 << W) - 64'(x)) : 64'(x);
        if (mag == 0) mag = 1;
        q = (64'd1 << (2 * N)) / mag;
        sat = (q > 64'(NSAT));
        res = sat ? NSAT : W'(q);
        if (!ab && x[W-1]) res = -res;
        return {sat, res};
    endfunction

    // behavioural device: done rises 4 cycles after the start cycle, cleared on start
    int dcnt = 0;
    bit dbusy = 1'b0;
    logic [W:0] pend = '0;
    always @(posedge i_clk) begin
        if (i_reset) begin
            dev_done <= 1'b0;
            dbusy    <= 1'b0;
        end else if (o_rcp_start) begin
            dev_done <= 1'b0;
            dev_data <= W'($urandom);
            dbusy    <= !((cyc == sx_c && hang_x) || (cyc == sy_c && hang_y));
            dcnt     <= 3;
            pend     <= dev_fn(o_rcp_data, o_rcp_abs);
        end else if (inj) begin
            dev_done <= 1'b1;
            dev_data <= W'($urandom);
            dev_sat  <= 1'b1;
        end else if (dbusy) begin
            if (dcnt == 1) begin
                dev_done <= 1'b1;
                dev_data <= pend[W-1:0];
                dev_sat  <= pend[W];
                dbusy    <= 1'b0;
            end else dcnt <= dcnt - 1;
        end
    end

    // per-cycle comparison against the model timeline
    always @(negedge i_clk) begin : cmp
        bit in_txn, exp_start, exp_valid;
        if (chk_en) begin
            in_txn    = active && cyc > a_c && cyc <= e_c;
            exp_start = active && (cyc == sx_c || cyc == sy_c);
            exp_valid = active && cyc >= v_c && cyc <= e_c;
            chk("ready", 64'(o_ready), 64'(!in_txn));
            chk("start", 64'(o_rcp_start), 64'(exp_start));
            chk("valid", 64'(o_valid), 64'(exp_valid));
            if (exp_start && o_rcp_start) begin
                chk("rcp_data", 64'(o_rcp_data), 64'((cyc == sx_c) ? e_xop : e_yop));
                chk("rcp_abs", 64'(o_rcp_abs), 64'(e_abs));
            end
            if (exp_valid && o_valid) begin
                chk("rx", 64'(o_rx), 64'(e_rx));
                chk("ry", 64'(o_ry), 64'(e_ry));
                chk("sat_x", 64'(o_sat_x), 64'(e_sx));
                chk("sat_y", 64'(o_sat_y), 64'(e_sy));
                chk("timeout", 64'(o_timeout), 64'(e_to));
            end
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(o_ready), 64'd1);
        chk({tag, "_start"}, 64'(o_rcp_start), 64'd0);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_rx"}, 64'(o_rx), 64'd0);
        chk({tag, "_ry"}, 64'(o_ry), 64'd0);
        chk({tag, "_rdata"}, 64'(o_rcp_data), 64'd0);
        chk({tag, "_flags"}, 64'({o_sat_x, o_sat_y, o_timeout, o_rcp_abs}), 64'd0);
    endtask

    // One request, called at posedge+1 of the accept cycle. rst_off >= 0 asserts
    // reset that many cycles after the Y start. lit enables literal pins.
    task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input bit ab,
                       input bit hx, input bit hy, input int bp, input int rst_off,
                       input bit lit, input int lv, input logic [W-1:0] lrx,
                       input logic [W-1:0] lry, input bit lsx, input bit lsy, input bit lto);
        int a, t, e;
        logic [W:0] r;
        a = cyc; t = a + 1;
        hang_x = hx && (x != 0);
        hang_y = hy && (y != 0);
        sx_c = -1; sy_c = -1;
        if (x != 0) begin sx_c = t; t += hang_x ? 1 + TIMEOUT : 5; end else t += 1;
        if (y != 0) begin sy_c = t; t += hang_y ? 1 + TIMEOUT : 5; end else t += 1;
        r = dev_fn(x, ab);
        {e_sx, e_rx} = (x == 0 || hang_x) ? {1'b1, NSAT} : r;
        r = dev_fn(y, ab);
        {e_sy, e_ry} = (y == 0 || hang_y) ? {1'b1, NSAT} : r;
        e_to = hang_x || hang_y;
        e_xop = x; e_yop = y; e_abs = ab;
        a_c = a; v_c = t; e = t + bp; e_c = e;
        active = 1'b1;
        i_valid = 1'b1; i_x = x; i_y = y; i_abs = ab; i_ready = 1'b0;
        forever begin
            tick();
            inj = 1'b0;
            if (i_reset) begin
                i_reset = 1'b0;
                break;
            end
            if (cyc > e) break;
            i_valid = (cyc < v_c) ? 1'($urandom) : 1'b0;
            i_x = W'($urandom); i_y = W'($urandom); i_abs = 1'($urandom);
            i_ready = (cyc >= v_c) ? (cyc == e) : 1'($urandom);
            inj = (cyc == v_c) && (bp >= 1);
            if (rst_off >= 0 && cyc == sy_c + rst_off) begin
                i_reset = 1'b1; e = cyc; e_c = cyc; inj = 1'b0;
            end
            if (lit && cyc == a + lv - 1) chk("lit_valid_lo", 64'(o_valid), 64'd0);
            if (lit && cyc == a + lv) begin
                chk("lit_valid", 64'(o_valid), 64'd1);
                chk("lit_rx", 64'(o_rx), 64'(lrx));
                chk("lit_ry", 64'(o_ry), 64'(lry));
                chk("lit_flags", 64'({o_sat_x, o_sat_y, o_timeout}), 64'({lsx, lsy, lto}));
            end
        end
        i_valid = 1'b0; i_ready = 1'b0;
        if (rst_off >= 0) chk_reset_vals("abort");
    endtask

    initial begin
        tick(); tick();
        chk_reset_vals("reset");
        i_reset = 1'b0;
        chk_en = 1'b1;
        tick();
        // normal pair: 2.0 and 0.5
        run(24'h002000, 24'h000800, 0, 0, 0, 1, -1, 1, 11, 24'h000800, 24'h002000, 0, 0, 0);
        // -2.0 with and without abs
        run(24'hFFE000, 24'hFFE000, 1, 0, 0, 0, -1, 1, 11, 24'h000800, 24'h000800, 0, 0, 0);
        tick();
        run(24'hFFE000, 24'hFFE000, 0, 0, 0, 2, -1, 1, 11, 24'hFFF800, 24'hFFF800, 0, 0, 0);
        // zero X
        run(24'h000000, 24'h001000, 0, 0, 0, 1, -1, 1, 7, NSAT, 24'h001000, 1, 0, 0);
        // hung device on X, late done injected in OUT
        run(24'h002000, 24'h000800, 0, 1, 0, 3, -1, 1, 22, NSAT, 24'h002000, 1, 0, 1);
        // hung device on Y
        run(24'h000800, 24'h002000, 0, 0, 1, 2, -1, 1, 22, 24'h002000, NSAT, 0, 1, 1);
        // back-pressure for 20 cycles
        run(24'h004000, 24'hFFF000, 0, 0, 0, 20, -1, 1, 11, 24'h000400, 24'hFFF000, 0, 0, 0);
        // both zero
        run(24'h000000, 24'h000000, 1, 0, 0, 1, -1, 1, 3, NSAT, NSAT, 1, 1, 0);
        // reset in WAIT_Y, then a normal request
        run(24'h002000, 24'h000800, 0, 0, 0, 1, 2, 0, 0, '0, '0, 0, 0, 0);
        run(24'h001000, 24'h002000, 0, 0, 0, 0, -1, 1, 11, 24'h001000, 24'h000800, 0, 0, 0);
        // randomized requests
        for (int k = 0; k < 60; k++) begin
            logic [W-1:0] rx_in, ry_in;
            int gap;
            rx_in = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom >> $urandom_range(0, 20));
            ry_in = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom >> $urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) rx_in = -rx_in;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            run(rx_in, ry_in, 1'($urandom), $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 4), -1,
                0, 0, '0, '0, 0, 0, 0);
        end
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rcp_sequencer.md
# rcp_sequencer

Initiator-side controller for the `reciprocal_fsm` start/done device port. It accepts a pair of SQM.N operands, typically ray direction X and Y, and drives one shared reciprocal device to compute each reciprocal in turn. It then presents both results together on a valid/ready output. It sits between the ray tracer's per-ray setup stage and the reciprocal device, and handles zero operands and a hung device without stalling the tracer.

## Interface
- `M`, 12, integer bits including sign
- `N`, 12, fractional bits
- `TIMEOUT`, 15, maximum cycles spent waiting for device done per operand (≥1)
- `i_clk`  in  1  clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_valid`  in  1  request operands present
- `o_ready`  out  1  sequencer can accept a request
- `i_x`, `i_y`  in  M+N  SQM.N operands
- `i_abs`  in  1  1 = magnitude-only reciprocals for this request
- `o_rcp_start`  out  1  one-cycle start pulse to device
- `o_rcp_data`  out  M+N  operand to device
- `o_rcp_abs`  out  1  abs flag to device
- `i_rcp_data`  in  M+N  device result
- `i_rcp_sat`  in  1  device saturation flag
- `i_rcp_done`  in  1  device result ready
- `o_valid`  out  1  results present
- `i_ready`  in  1  consumer takes results
- `o_rx`, `o_ry`  out  M+N  reciprocals of X and Y
- `o_sat_x`, `o_sat_y`  out  1  per-result saturation
- `o_timeout`  out  1  at least one operand in this result timed out

## Operation
- States: IDLE, ISSUE_X, WAIT_X, ISSUE_Y, WAIT_Y, OUT.
- IDLE:
  - `o_ready`=1 only in IDLE.
  - On `i_valid`&`o_ready`, latch `i_x`, `i_y`, `i_abs`, clear the timeout flag, and go to ISSUE_X.
- ISSUE_x (x ∈ {X,Y}):
  - If the latched operand ≠ 0: assert `o_rcp_start` for exactly this cycle, with `o_rcp_data`=operand and `o_rcp_abs`=latched abs. Load the wait counter with TIMEOUT and go to WAIT_x.
  - If the operand = 0: no start. Result = nSat (0x7FF…F, i.e. ~(1<<(M+N-1))), sat=1. Go to the next ISSUE state, or to OUT from Y.
- WAIT_x:
  - If `i_rcp_done`=1: capture `i_rcp_data` and `i_rcp_sat` and go to the next state.
  - Otherwise decrement the counter. When it reaches 0 without done: result = nSat, sat=1, set the timeout flag, and advance.
  - The device clears done on the clock edge that samples start. Done seen in any WAIT cycle is therefore fresh.
- OUT:
  - `o_valid`=1 with all outputs stable.
  - On `i_ready`, go to IDLE. A new request is accepted no earlier than the following cycle.
- `o_rcp_data` and `o_rcp_abs` hold their last driven value outside ISSUE.
- Results are passed through unmodified; the device applies sign restoration.
- A late done arriving after a timeout is ignored. This covers the IDLE/OUT states and any later ISSUE.

## Timing
- Reset values:
  - State = IDLE.
  - `o_ready`=1.
  - `o_rcp_start`=0, `o_valid`=0.
  - `o_rx`=`o_ry`=0, `o_rcp_data`=0.
  - `o_sat_x`=`o_sat_y`=`o_timeout`=0, `o_rcp_abs`=0.
- Reset mid-operation aborts immediately: next cycle is IDLE with start low. The device shares `i_reset`.
- Device latency: done rises 4 cycles after the start cycle.
- Request accepted in cycle A, both operands nonzero:
  - Start in A+1 and A+6.
  - Done in A+5 and A+10.
  - `o_valid` from A+11.
- X=0: start in A+2, `o_valid` from A+7.
- Both zero: `o_valid` from A+3.
- Timeout on X with Y normal: X waits TIMEOUT cycles from A+2, then ISSUE_Y.
- `o_valid` holds indefinitely under back-pressure. `o_rcp_start` stays 0 while in OUT.

## Test plan
- Normal request, M=N=12: x=0x002000 (2.0), y=0x000800 (0.5), abs=0, behavioural device (4-cycle) -> starts at A+1 and A+6; `o_valid` at A+11; `o_rx`=0x000800 and `o_ry`=0x002000 within 2 LSB; sats=0, `o_timeout`=0.
- Negative with abs: x=0xFFE000 (-2.0), y=0xFFE000; run with abs=1, then with abs=0 -> `o_rx` ≈0x000800 for abs=1, ≈0xFFF800 for abs=0; `o_rcp_abs` matches on each start.
- Zero operand: x=0, y=0x001000 -> only one start (A+2); `o_rx`=0x7FFFFF, `o_sat_x`=1, `o_ry`≈0x001000; `o_valid` at A+7.
- Hung device on X (done never rises), TIMEOUT=15 -> ISSUE_Y occurs after 15 WAIT_X cycles; `o_rx`=0x7FFFFF, `o_sat_x`=1, `o_timeout`=1; a late done injected during OUT changes nothing.
- Back-pressure: `i_ready`=0 for 20 cycles in OUT -> `o_valid` and data stable; `o_ready`=0; no start pulses; IDLE the cycle after `i_ready`.
- Reset asserted in WAIT_Y -> next cycle all outputs at reset values, `o_ready`=1; a following request completes normally.
